noc_out_arbiter: RTL and testbench

Round-robin wormhole arbiter for one NoC router output port. It shares the port among NUM_IN input queues. Each packet is granted head-to-tail without interleaving, and flits are sent only while credits for the downstream buffer are available. It sits between the per-input `queue` instances and the output link. It drives each queue's dequeue strobe and registers the selected flit onto the link.

---
 rtl/noc_out_arbiter.sv | 134 +++++++++++++
 tb/tb_noc_out_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_out_arbiter.sv
// Round-robin wormhole arbiter for one router output port: holds the port for
// a whole packet and only forwards flits while downstream credits remain.
module noc_out_arbiter #(
    parameter int NUM_IN  = 5,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = 4,
    localparam int CNT_W  = $clog2(CREDITS + 1),
    localparam int IDX_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN-1:0]        in_tail,
    input  logic [NUM_IN*FLIT_W-1:0] in_data,
    output logic [NUM_IN-1:0]        pop,
    input  logic                     credit_in,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_tail,
    output logic [NUM_IN-1:0]        grant,
    output logic                     cred_err,
    output logic                     dbg_state,
    output logic [CNT_W-1:0]         dbg_cnt
);

    // Handshake: a flit moves from queue w exactly in cycles where pop[w]=1,
    // i.e. w owns the port, in_valid[w]=1 and at least one credit is held;
    // each credit_in pulse returns one downstream slot.

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    w_q, w_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_IN-1:0]   grant_d;
    logic                err_d;
    logic                send;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_IN) s = s - NUM_IN;
        return IDX_W'(s);
    endfunction

    // Descending scan so the lowest offset from ptr is the last to assign.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (in_valid[wrap_idx(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(ptr_q, k);
            end
        end
    end

    assign send = (state_q == LOCK) && in_valid[w_q] && (cnt_q != '0);

    always_comb begin
        pop = '0;
        if (send) pop[w_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        ptr_d   = ptr_q;
        grant_d = grant;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = LOCK;
                    w_d              = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end
            LOCK: begin
                if (send && in_tail[w_q]) begin
                    state_d = IDLE;
                    ptr_d   = (w_q == IDX_W'(NUM_IN - 1)) ? '0 : w_q + IDX_W'(1);
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A credit arriving while the counter is full has nowhere to go.
    always_comb begin
        cnt_d = cnt_q;
        err_d = cred_err;
        if (send && !credit_in) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (!send && credit_in) begin
            if (cnt_q == CNT_W'(CREDITS)) err_d = 1'b1;
            else                          cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            w_q       <= '0;
            ptr_q     <= '0;
            cnt_q     <= CNT_W'(CREDITS);
            grant     <= '0;
            cred_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tail  <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant     <= grant_d;
            cred_err  <= err_d;
            out_valid <= send;
            if (send) begin
                out_data <= in_data[int'(w_q) * FLIT_W +: FLIT_W];
                out_tail <= in_tail[w_q];
            end
        end
    end

    assign dbg_state = (state_q == LOCK);
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter: scripted queue traffic and credit pulses,
// an abstract port-sharing model compared every cycle, plus literal checks.
module tb_noc_out_arbiter;

    localparam int NUM_IN  = 5;
    localparam int FLIT_W  = 32;
    localparam int CREDITS = 4;
    localparam int CNT_W   = $clog2(CREDITS + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b1;
    logic [NUM_IN-1:0]        in_valid = '0;
    logic [NUM_IN-1:0]        in_tail = '0;
    logic [NUM_IN*FLIT_W-1:0] in_data = '0;
    logic [NUM_IN-1:0]        pop;
    logic                     credit_in = 1'b0;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_data;
    logic                     out_tail;
    logic [NUM_IN-1:0]        grant;
    logic                     cred_err;
    logic                     dbg_state;
    logic [CNT_W-1:0]         dbg_cnt;

    noc_out_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_tail(in_tail),
        .in_data(in_data), .pop(pop), .credit_in(credit_in),
        .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail),
        .grant(grant), .cred_err(cred_err), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- upstream queue emulation ----------------
    logic [FLIT_W:0]   fmem [NUM_IN][16];
    int                rd [NUM_IN];
    int                wr [NUM_IN];
    bit                starve [NUM_IN];
    logic [NUM_IN-1:0] pop_s = '0;

    task automatic push(input int q, input logic [FLIT_W-1:0] d, input bit t);
        fmem[q][wr[q] % 16] = {t, d};
        wr[q]++;
    endtask

    task automatic drive_inputs();
        logic [FLIT_W:0] head;
        for (int i = 0; i < NUM_IN; i++) begin
            head = fmem[i][rd[i] % 16];
            if (wr[i] != rd[i] && !starve[i]) begin
                in_valid[i] = 1'b1;
                in_tail[i]  = head[FLIT_W];
                in_data[i*FLIT_W +: FLIT_W] = head[FLIT_W-1:0];
            end else begin
                in_valid[i] = 1'b0;
                in_tail[i]  = 1'b0;
                in_data[i*FLIT_W +: FLIT_W] = '0;
            end
        end
    endtask

    // Advance one cycle: retire popped heads, apply new inputs, stop at negedge.
    task automatic tick(input bit cred);
        @(posedge clk);
        for (int i = 0; i < NUM_IN; i++)
            if (pop_s[i] && rd[i] != wr[i]) rd[i]++;
        #1;
        credit_in = cred;
        drive_inputs();
        @(negedge clk);
        pop_s = pop;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_grant", grant, 0);
        check("rst_pop", pop, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cred_err", cred_err, 0);
        check("rst_state", dbg_state, 0);
        check("rst_cnt", dbg_cnt, CREDITS);
        for (int i = 0; i < NUM_IN; i++) begin
            rd[i] = 0; wr[i] = 0; starve[i] = 1'b0;
        end
        credit_in = 1'b0;
        drive_inputs();
        pop_s = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    bit                m_locked;
    int                m_owner, m_ptr, m_cnt;
    bit                m_err, m_ov, m_tail;
    logic [FLIT_W-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin : model
        bit snd, found;
        int c;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = CREDITS;
            m_err = 0; m_ov = 0; m_tail = 0; m_data = '0;
        end else begin
            snd = m_locked && in_valid[m_owner] && (m_cnt > 0);
            m_ov = snd;
            if (snd) begin
                m_data = in_data[m_owner*FLIT_W +: FLIT_W];
                m_tail = in_tail[m_owner];
            end
            c = m_cnt - int'(snd) + int'(credit_in);
            if (c > CREDITS) begin
                c = CREDITS;
                m_err = 1;
            end
            m_cnt = c;
            if (!m_locked) begin
                found = 0;
                for (int k = 0; k < NUM_IN; k++) begin
                    if (!found && in_valid[(m_ptr + k) % NUM_IN]) begin
                        found = 1;
                        m_owner = (m_ptr + k) % NUM_IN;
                    end
                end
                if (found) m_locked = 1;
            end else if (snd && in_tail[m_owner]) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % NUM_IN;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : compare
        logic [NUM_IN-1:0] e_pop, e_grant;
        e_pop = '0;
        e_grant = '0;
        if (m_locked) e_grant[m_owner] = 1'b1;
        if (m_locked && in_valid[m_owner] && m_cnt > 0) e_pop[m_owner] = 1'b1;
        check("pop", pop, e_pop);
        check("grant", grant, e_grant);
        check("out_valid", out_valid, m_ov);
        check("out_data", out_data, m_data);
        check("out_tail", out_tail, m_tail);
        check("cred_err", cred_err, m_err);
        check("state", dbg_state, m_locked);
        check("cnt", dbg_cnt, m_cnt);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [FLIT_W-1:0] ed;
        for (int i = 0; i < NUM_IN; i++) begin
            rd[i] = 0; wr[i] = 0; starve[i] = 1'b0;
        end
        do_reset();

        // Reset mid-packet from queue 1
        push(1, 32'h10, 0); push(1, 32'h11, 0); push(1, 32'h12, 1);
        tick(0); tick(0); tick(0);
        check("mid_out_valid", out_valid, 1);
        do_reset();

        // Pointer restarts at 0: queue 0 beats queue 4
        push(0, 32'h01, 1); push(4, 32'h04, 1);
        tick(0);
        tick(0); check("t1_grant0", grant, 5'b00001); check("t1_pop0", pop, 5'b00001);
        tick(0); check("t1_data0", out_data, 32'h01); check("t1_idle", grant, 0);
        tick(0); check("t1_grant4", grant, 5'b10000);
        tick(0); check("t1_data4", out_data, 32'h04);
        tick(1); tick(1); tick(0);
        check("t1_cnt_full", dbg_cnt, 4);

        // Single 3-flit packet from queue 2
        push(2, 32'hA0, 0); push(2, 32'hA1, 0); push(2, 32'hA2, 1);
        tick(0);
        tick(0); check("t2_grant", grant, 5'b00100); check("t2_pop", pop, 5'b00100);
        tick(0); check("t2_v0", out_valid, 1); check("t2_d0", out_data, 32'hA0);
        tick(0); check("t2_v1", out_valid, 1); check("t2_d1", out_data, 32'hA1);
        tick(0); check("t2_d2", out_data, 32'hA2); check("t2_tail", out_tail, 1);
        check("t2_grant_end", grant, 0); check("t2_cnt", dbg_cnt, 1);
        check("t2_model_ptr", m_ptr, 3);

        // Send and credit in the same cycle at cnt=1
        push(3, 32'h30, 1);
        tick(0);
        tick(1); check("t5_pop", pop, 5'b01000);
        tick(0); check("t5_data", out_data, 32'h30); check("t5_cnt", dbg_cnt, 1);
        do_reset();

        // Fairness with a credit every cycle
        for (int q = 0; q < NUM_IN; q++) begin
            push(q, 32'h100 + q*16, 1);
            push(q, 32'h101 + q*16, 1);
        end
        tick(1);
        for (int k = 0; k < 7; k++) begin
            ed = 32'h100 + (k % 5) * 16 + k / 5;
            tick(1); check("t3_grant", grant, 5'b00001 << (k % 5));
            tick(1); check("t3_gap", grant, 0); check("t3_data", out_data, ed);
        end
        repeat (8) tick(0);
        do_reset();

        // Credit stall: bring cnt to 2, then a 4-flit packet from queue 1
        push(0, 32'h50, 0); push(0, 32'h51, 1);
        repeat (4) tick(0);
        check("t4_cnt2", dbg_cnt, 2);
        push(1, 32'hB0, 0); push(1, 32'hB1, 0); push(1, 32'hB2, 0); push(1, 32'hB3, 1);
        tick(0);
        tick(0); check("t4_grant", grant, 5'b00010);
        tick(0); check("t4_b0", out_data, 32'hB0);
        tick(0); check("t4_b1", out_data, 32'hB1); check("t4_pop_stall", pop, 0);
        tick(0); check("t4_ov_stall", out_valid, 0); check("t4_hold", grant, 5'b00010);
        tick(1); check("t4_p1_pop", pop, 0);
        tick(0); check("t4_p1_pop_next", pop, 5'b00010);
        tick(0); check("t4_b2", out_data, 32'hB2); check("t4_b2v", out_valid, 1); check("t4_p1_once", pop, 0);
        tick(1); check("t4_p2_pop", pop, 0); check("t4_p2_ov", out_valid, 0);
        tick(0); check("t4_p2_pop_next", pop, 5'b00010);
        tick(0); check("t4_b3", out_data, 32'hB3); check("t4_b3_tail", out_tail, 1);
        check("t4_grant_end", grant, 0);

        // Starved owner keeps the port
        repeat (4) tick(1);
        push(3, 32'hC0, 0); push(3, 32'hC1, 0); push(3, 32'hC2, 1);
        push(0, 32'hD0, 1); push(4, 32'hE0, 1);
        tick(0);
        tick(0); check("t6_grant3", grant, 5'b01000);
        starve[3] = 1'b1;
        tick(0); check("t6_c0", out_data, 32'hC0); check("t6_pop_starve", pop, 0);
        tick(0); check("t6_hold_a", grant, 5'b01000); check("t6_ov_a", out_valid, 0);
        tick(0); check("t6_hold_b", grant, 5'b01000);
        starve[3] = 1'b0;
        tick(0); check("t6_resume", pop, 5'b01000);
        tick(0); check("t6_c1", out_data, 32'hC1);
        tick(0); check("t6_c2", out_data, 32'hC2); check("t6_release", grant, 0);
        tick(0); check("t6_next_q4", grant, 5'b10000);
        tick(1); check("t6_e0", out_data, 32'hE0);
        tick(0); check("t6_then_q0", grant, 5'b00001); check("t6_pop_q0", pop, 5'b00001);
        tick(0); check("t6_d0", out_data, 32'hD0);
        do_reset();

        // Credit overflow while idle is sticky
        tick(1);
        tick(0); check("t5_err", cred_err, 1); check("t5_cnt_sat", dbg_cnt, 4);
        push(0, 32'h77, 1);
        repeat (5) tick(0);
        check("t5_err_sticky", cred_err, 1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
